sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word width in bits (legal range 2..32).
REQ-002 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-003 Port areset, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-004 Port clr, input, 1, SHALL be a synchronous clear that discards any partial frame.
REQ-005 Port ena, input, 1, SHALL qualify sin as one valid serial bit this cycle.
REQ-006 Port sin, input, 1, SHALL carry serial data, first bit = word LSB (matches the team's right-shifting serializer).
REQ-007 Port out_ready, input, 1, SHALL be the downstream accept signal.
REQ-008 Port out_valid, output, 1, SHALL indicate q holds an unconsumed word.
REQ-009 Port q, output, WIDTH, SHALL be the registered parallel word.
REQ-010 Port overrun, output, 1, SHALL be a sticky flag for a dropped word.
REQ-011 Port parity_err, output, 1, SHALL be the parity-error flag qualified by out_valid (see Configuration).

Function
REQ-012 Priority SHALL be: areset > clr > ena; with ena low and clr low, shift state SHALL hold.
REQ-013 On ena, the shift register SHALL load {sin, shreg[WIDTH-1:1]} and bit counter SHALL increment.
REQ-014 When the counter reaches frame length (WIDTH, or WIDTH+1 with parity), the counter SHALL wrap to 0 in the same cycle and the frame SHALL complete.
REQ-015 Frame completion with output buffer EMPTY SHALL load q and set out_valid on the next clock edge (1-cycle latency after the last-bit edge).
REQ-016 Output buffer FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 FULL -> EMPTY SHALL occur on out_valid && out_ready with no simultaneous frame completion.
REQ-018 Handshake and frame completion in the same cycle SHALL load the new word, stay FULL, and SHALL NOT set overrun.
REQ-019 Frame completion while FULL and out_ready=0 SHALL drop the new word, keep q unchanged, and set overrun.
REQ-020 overrun SHALL clear only on areset or clr.
REQ-021 q SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Collection SHALL continue while FULL (double-buffered); ena is never back-pressured.
REQ-023 clr SHALL zero the counter and shift register, force EMPTY, and clear overrun; an ena in the same cycle SHALL be ignored.

Reset
REQ-024 areset SHALL immediately force q=0, out_valid=0, overrun=0, parity_err=0, counter=0, shift register=0, state EMPTY.
REQ-025 areset mid-frame SHALL discard all partial bits; the first ena after release SHALL be bit 0 of a new frame.

Configuration
REQ-026 Macro SIPO_DESER_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit; parity_err loads with q = (XOR of data bits != parity bit); the parity bit SHALL NOT enter q.
REQ-027 Macro undefined: frame = WIDTH bits; parity_err SHALL be tied 0.

Structure
REQ-028 A shared package sipo_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the parity-bit constant (0 or 1).
REQ-029 Counter width SHALL be $clog2(WIDTH+2) bits.
REQ-030 Sub-module sipo_shift_core SHALL contain the shift register and counter, with outputs frame_done and word; the FSM and output buffer SHALL reside in the top module.

Verification
REQ-031 WIDTH=4, no parity, out_ready=1, sin 1,0,1,1 on consecutive ena cycles -> one cycle later out_valid=1 and q=4'b1101.
REQ-032 out_ready=0, send 4'b1101, then a second frame 4'b0011 -> q stays 4'b1101 and overrun=1; clr pulse -> overrun=0 and out_valid=0.
REQ-033 out_ready asserted in the same cycle as the second frame's last bit -> q=4'b0011, out_valid=1, overrun=0.
REQ-034 After 2 bits, pulse areset, then send 0,1,1,0 -> q=4'b0110 with no residual bits.
REQ-035 ena gaps: bits 1,1,0,0 with idle cycles between them -> q=4'b0011; the counter is not advanced by idle cycles.
REQ-036 With SIPO_DESER_PARITY_EN, send 1,0,1,1 then parity 1 -> parity_err=0; with parity 0 -> parity_err=1; q=4'b1101 in both cases.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the sipo_deser serial-to-parallel deserializer.
// Optional feature macro: SIPO_DESER_PARITY_EN (adds one even-parity bit per frame).
package sipo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

`ifdef SIPO_DESER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: collects one frame LSB-first and pulses frame_done
// on the cycle after the last bit is captured. Macro SIPO_DESER_PARITY_EN adds par_bit.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             ena,
  input  logic             sin,
  output logic             frame_done,
  output logic [WIDTH-1:0] word
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic             par_bit
`endif
);

  localparam int FRAME_LEN = WIDTH + int'(PARITY_BITS);
  localparam int CNT_W     = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (ena) begin
      shreg_d = {sin, shreg_q[FRAME_LEN-1:1]};
      if (cnt_q == LAST_BIT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // After the last bit, the first bit received sits at shreg_q[0].
  assign frame_done = done_q;
  assign word       = shreg_q[WIDTH-1:0];
`ifdef SIPO_DESER_PARITY_EN
  assign par_bit    = shreg_q[FRAME_LEN-1];
`endif

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-word valid/ready output buffer.
// Macro SIPO_DESER_PARITY_EN enables an even-parity bit per frame and parity_err.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             clr,
  input  logic             ena,
  input  logic             sin,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             overrun,
  output logic             parity_err
);

  logic             frame_done;
  logic [WIDTH-1:0] word;
  logic             perr_new;

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ovr_q, ovr_d;
  logic             perr_q, perr_d;

`ifdef SIPO_DESER_PARITY_EN
  logic par_bit;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .areset     (areset),
    .clr        (clr),
    .ena        (ena),
    .sin        (sin),
    .frame_done (frame_done),
    .word       (word),
    .par_bit    (par_bit)
  );

  // Even parity: data bits plus parity bit must XOR to zero.
  assign perr_new = (^word) ^ par_bit;
`else
  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .areset     (areset),
    .clr        (clr),
    .ena        (ena),
    .sin        (sin),
    .frame_done (frame_done),
    .word       (word)
  );

  assign perr_new = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    if (clr) begin
      state_d = EMPTY;
      ovr_d   = 1'b0;
      perr_d  = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (frame_done) begin
            state_d = FULL;
            q_d     = word;
            perr_d  = perr_new;
          end
        end
        FULL: begin
          if (frame_done) begin
            // A same-cycle handshake frees the slot; otherwise the new word is lost.
            if (out_ready) begin
              q_d    = word;
              perr_d = perr_new;
            end else begin
              ovr_d = 1'b1;
            end
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= EMPTY;
      q_q     <= '0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign q          = q_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q & out_valid;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus randomized traffic,
// checked by a frame-level reference model feeding a scoreboard queue.
module tb_sipo_deser;

  localparam int WIDTH = 4;
`ifdef SIPO_DESER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = WIDTH + PB;

  logic             clk;
  logic             areset;
  logic             clr;
  logic             ena;
  logic             sin;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] q;
  logic             overrun;
  logic             parity_err;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .areset     (areset),
    .clr        (clr),
    .ena        (ena),
    .sin        (sin),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .q          (q),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are lists of bits; the output side is a one-word slot.
  typedef struct {
    logic [WIDTH-1:0] w;
    logic             p;
  } exp_t;

  exp_t             sb[$];
  bit               m_bits[$];
  bit               m_pend_v;
  logic [WIDTH-1:0] m_pend_w;
  logic             m_pend_p;
  bit               m_full;
  logic [WIDTH-1:0] m_word;
  logic             m_perr;
  bit               m_ovr;

  // Inputs present at the upcoming clock edge.
  logic p_c, p_e, p_s, p_r;

  function automatic void model_reset();
    m_bits.delete();
    sb.delete();
    m_pend_v = 0;
    m_full   = 0;
    m_word   = '0;
    m_perr   = 1'b0;
    m_ovr    = 0;
  endfunction

  // Advance the model by one clock edge with the inputs seen at that edge.
  function automatic void model_step(input logic c, input logic e, input logic s, input logic r);
    bit hs;
    hs = m_full && r;
    if (c) begin
      if (m_full) void'(sb.pop_back());
      m_bits.delete();
      m_pend_v = 0;
      m_full   = 0;
      m_ovr    = 0;
      return;
    end
    if (m_pend_v) begin
      if (!m_full || hs) begin
        m_full = 1;
        m_word = m_pend_w;
        m_perr = m_pend_p;
        sb.push_back('{w: m_pend_w, p: m_pend_p});
      end else begin
        m_ovr = 1;
      end
    end else if (hs) begin
      m_full = 0;
    end
    m_pend_v = 0;
    if (e) begin
      m_bits.push_back(s);
      if (m_bits.size() == FRAME) begin
        int ones;
        ones = 0;
        for (int i = 0; i < FRAME; i++) ones += int'(m_bits[i]);
        m_pend_w = '0;
        for (int i = 0; i < WIDTH; i++) m_pend_w[i] = m_bits[i];
        m_pend_p = (PB == 1) ? logic'(ones % 2) : 1'b0;
        m_pend_v = 1;
        m_bits.delete();
      end
    end
  endfunction

  task automatic cyc(input logic c, input logic e, input logic s, input logic r);
    @(posedge clk);
    #1;
    model_step(p_c, p_e, p_s, p_r);
    clr = c; ena = e; sin = s; out_ready = r;
    p_c = c; p_e = e; p_s = s; p_r = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    model_step(p_c, p_e, p_s, p_r);
    areset = 1'b1;
    clr = 0; ena = 0; sin = 0; out_ready = 0;
    p_c = 0; p_e = 0; p_s = 0; p_r = 0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    #1;
    areset = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic par, input logic r, input int gap);
    for (int i = 0; i < WIDTH; i++) begin
      cyc(1'b0, 1'b1, w[i], r);
      repeat (gap) cyc(1'b0, 1'b0, 1'b0, r);
    end
    if (PB == 1) cyc(1'b0, 1'b1, par, r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, r);
  endtask

  // Monitor: compares every cycle against the model and pops on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset) begin
        check("out_valid", out_valid, m_full);
        check("overrun", overrun, m_ovr);
        if (m_full) check("q_hold", q, m_word);
        check("parity_err", parity_err, m_full ? m_perr : 1'b0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL hs_unexpected: got word %0h expected no word (t=%0t)", q, $time);
          end else begin
            e = sb.pop_front();
            check("hs_word", q, e.w);
            check("hs_perr", parity_err, e.p);
          end
        end
      end
    end
  end

  initial begin
    areset = 1'b1;
    clr = 0; ena = 0; sin = 0; out_ready = 0;
    p_c = 0; p_e = 0; p_s = 0; p_r = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_q", q, 0);
    check("init_overrun", overrun, 0);
    areset = 1'b0;

    // Basic frame, one-cycle load latency after the last bit.
    do_reset();
    send_word(4'b1101, 1'b1, 1'b1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("d1_latency_valid", out_valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("d1_valid", out_valid, 1);
    check("d1_q", q, 4'b1101);

    // Overrun: second frame dropped, then clr.
    do_reset();
    send_word(4'b1101, 1'b1, 1'b0, 0);
    idle(2, 1'b0);
    send_word(4'b0011, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    @(negedge clk);
    check("d2_q", q, 4'b1101);
    check("d2_overrun", overrun, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("d2_clr_overrun", overrun, 0);
    check("d2_clr_valid", out_valid, 0);

    // Handshake coincident with frame completion.
    do_reset();
    send_word(4'b1101, 1'b1, 1'b0, 0);
    idle(2, 1'b0);
    send_word(4'b0011, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("d3_q", q, 4'b0011);
    check("d3_valid", out_valid, 1);
    check("d3_overrun", overrun, 0);

    // Reset mid-frame discards partial bits.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(4'b0110, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    @(negedge clk);
    check("d4_q", q, 4'b0110);

    // Idle gaps do not advance the bit count.
    do_reset();
    send_word(4'b0011, 1'b0, 1'b0, 2);
    idle(2, 1'b0);
    @(negedge clk);
    check("d5_q", q, 4'b0011);
    check("d5_valid", out_valid, 1);

`ifdef SIPO_DESER_PARITY_EN
    do_reset();
    send_word(4'b1101, 1'b1, 1'b0, 0);
    idle(2, 1'b0);
    @(negedge clk);
    check("d6_good_q", q, 4'b1101);
    check("d6_good_perr", parity_err, 0);
    do_reset();
    send_word(4'b1101, 1'b0, 1'b0, 0);
    idle(2, 1'b0);
    @(negedge clk);
    check("d6_bad_q", q, 4'b1101);
    check("d6_bad_perr", parity_err, 1);
`endif

    // Randomized traffic, including clr with ena in the same cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic c, e, s, r;
      c = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 60);
      s = 1'($urandom);
      r = c ? 1'b0 : 1'($urandom);
      cyc(c, e, s, r);
    end
    idle(10, 1'b1);
    @(negedge clk);
    check("drain_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
